// File: rtl/sysram_arbiter_pkg.sv
// Shared types and constants for the system-memory Wishbone arbiter.
package sysram_arbiter_pkg;

    localparam int MAX_MASTERS = 8;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // Round-robin successor of a master index, wrapping at n.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sysram_arbiter_if.sv
// Wishbone bundle between the intercon master ports, the arbiter and the memory slave.
interface sysram_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
    logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
    logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i;
    logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
    logic [NUM_MASTERS-1:0]        wbm_we_i;
    logic [NUM_MASTERS-1:0]        wbm_cyc_i;
    logic [NUM_MASTERS-1:0]        wbm_stb_i;
    logic [DW-1:0]                 wbm_dat_o;
    logic [NUM_MASTERS-1:0]        wbm_ack_o;
    logic [NUM_MASTERS-1:0]        wbm_err_o;
    logic [NUM_MASTERS-1:0]        wbm_rty_o;

    logic [AW-1:0]                 wbs_adr_o;
    logic [DW-1:0]                 wbs_dat_o;
    logic [DW/8-1:0]               wbs_sel_o;
    logic [2:0]                    wbs_cti_o;
    logic [1:0]                    wbs_bte_o;
    logic                          wbs_we_o;
    logic                          wbs_cyc_o;
    logic                          wbs_stb_o;
    logic [DW-1:0]                 wbs_dat_i;
    logic                          wbs_ack_i;
    logic                          wbs_err_i;
    logic                          wbs_rty_i;

    // The arbiter is the slave of the master ports and drives the memory port.
    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
               wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
               wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o,
               wbs_we_o, wbs_cyc_o, wbs_stb_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
               wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
               wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o,
               wbs_we_o, wbs_cyc_o, wbs_stb_o
    );

endinterface

// File: rtl/sysram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, with wrap.
module rr_pick
    import sysram_arbiter_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = int'(last_owner);
        for (int i = 0; i < N; i++) begin
            idx = next_index(idx, N);
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sysram_arbiter.sv
// Round-robin Wishbone B3 arbiter giving one master at a time the whole memory slave,
// with a per-transfer watchdog that aborts accesses the slave never answers.
module sysram_arbiter
    import sysram_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    sysram_arbiter_if.slave        bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o
);

    localparam int SW = DW / 8;
    localparam int OW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [OW-1:0] LAST_INIT = OW'(NUM_MASTERS - 1);

    arb_state_t             state, state_next;
    logic [OW-1:0]          owner, last_owner;
    logic [NUM_MASTERS-1:0] owner_grant;
    logic [CW-1:0]          wd_count;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [OW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   owner_cyc, owner_stb, slave_resp, wd_expire;
    logic [NUM_MASTERS-1:0] resp_gate;

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req        (bus.wbm_cyc_i),
        .last_owner (last_owner),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .valid      (pick_valid)
    );

    assign owner_cyc  = bus.wbm_cyc_i[owner];
    assign owner_stb  = bus.wbm_stb_i[owner];
    assign slave_resp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
    // A response landing in the expiry cycle wins over the abort.
    assign wd_expire  = (TIMEOUT_CYCLES != 0) && (state == OWN) && owner_cyc && owner_stb
                        && !slave_resp && (wd_count == CNT_LIMIT);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick_valid) state_next = OWN;
            OWN:     if (!owner_cyc) state_next = IDLE;
                     else if (wd_expire) state_next = ABORT;
            ABORT:   if (!owner_cyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            owner       <= '0;
            owner_grant <= '0;
            last_owner  <= LAST_INIT;
            wd_count    <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                owner       <= pick_idx;
                owner_grant <= pick_grant;
            end
            if (state != IDLE && state_next == IDLE) begin
                last_owner <= owner;
            end
            if (state != OWN || !owner_stb || slave_resp) begin
                wd_count <= '0;
            end else if (wd_count != CNT_LIMIT) begin
                wd_count <= wd_count + 1'b1;
            end
        end
    end

    // The slave sees the owner's request only while the cycle is owned; ABORT and IDLE park the bus at zero.
    always_comb begin
        bus.wbs_adr_o = '0;
        bus.wbs_dat_o = '0;
        bus.wbs_sel_o = '0;
        bus.wbs_cti_o = '0;
        bus.wbs_bte_o = '0;
        bus.wbs_we_o  = 1'b0;
        bus.wbs_cyc_o = 1'b0;
        bus.wbs_stb_o = 1'b0;
        if (state == OWN) begin
            bus.wbs_adr_o = bus.wbm_adr_i[owner*AW +: AW];
            bus.wbs_dat_o = bus.wbm_dat_i[owner*DW +: DW];
            bus.wbs_sel_o = bus.wbm_sel_i[owner*SW +: SW];
            bus.wbs_cti_o = bus.wbm_cti_i[owner*3 +: 3];
            bus.wbs_bte_o = bus.wbm_bte_i[owner*2 +: 2];
            bus.wbs_we_o  = bus.wbm_we_i[owner];
            bus.wbs_cyc_o = owner_cyc;
            bus.wbs_stb_o = owner_stb;
        end
    end

    assign resp_gate     = (state == OWN) ? owner_grant : '0;
    assign bus.wbm_ack_o = resp_gate & {NUM_MASTERS{bus.wbs_ack_i}};
    assign bus.wbm_err_o = resp_gate & {NUM_MASTERS{bus.wbs_err_i | wd_expire}};
    assign bus.wbm_rty_o = resp_gate & {NUM_MASTERS{bus.wbs_rty_i}};
    assign bus.wbm_dat_o = bus.wbs_dat_i;

    assign grant_o   = (state == IDLE) ? '0 : owner_grant;
    assign timeout_o = wd_expire;

endmodule

// File: tb/tb_sysram_arbiter.sv
// Self-checking bench for sysram_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level round-robin model.
module tb_sysram_arbiter;
    import sysram_arbiter_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic [NM-1:0] grant;
    logic          timeout;

    int total_checks  = 0;
    int passed_checks = 0;

    sysram_arbiter_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) bus ();

    sysram_arbiter #(
        .NUM_MASTERS    (NM),
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus),
        .grant_o    (grant),
        .timeout_o  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wbm_adr_i = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_sel_i = '0;
        bus.wbm_cti_i = '0;
        bus.wbm_bte_i = '0;
        bus.wbm_we_i  = '0;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;
        bus.wbs_rty_i = 1'b0;
    endtask

    task automatic set_master(input int k, input logic on, input logic we,
                              input logic [AW-1:0] adr, input logic [2:0] cti);
        bus.wbm_cyc_i[k]             = on;
        bus.wbm_stb_i[k]             = on;
        bus.wbm_we_i[k]              = we;
        bus.wbm_adr_i[k*AW +: AW]    = adr;
        bus.wbm_dat_i[k*DW +: DW]    = adr ^ 32'h5A5A_5A5A;
        bus.wbm_sel_i[k*(DW/8) +: DW/8] = '1;
        bus.wbm_cti_i[k*3 +: 3]      = cti;
        bus.wbm_bte_i[k*2 +: 2]      = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        set_master(0, 1'b1, 1'b1, 32'h1000, CTI_CLASSIC);
        bus.wbs_ack_i = 1'b1;
        tick();
        #1;
        total_checks++;
        if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o} !== 3'b000) begin
            $display("[TB] FAIL reset_slave_ctrl: got %b want 000", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o});
        end else passed_checks++;
        total_checks++;
        if ({bus.wbs_adr_o, bus.wbs_dat_o} !== '0) begin
            $display("[TB] FAIL reset_slave_bus: got adr %h dat %h want 0", bus.wbs_adr_o, bus.wbs_dat_o);
        end else passed_checks++;
        total_checks++;
        if ({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o, grant, timeout} !== '0) begin
            $display("[TB] FAIL reset_responses: got ack %b err %b rty %b grant %b to %b want 0",
                     bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o, grant, timeout);
        end else passed_checks++;
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        tick();
        set_master(1, 1'b1, 1'b0, 32'h0000_2040, CTI_CLASSIC);
        #1;
        total_checks++;
        if ({bus.wbs_cyc_o, grant} !== 4'b0000) begin
            $display("[TB] FAIL single_latency: got cyc %b grant %b want 0 000", bus.wbs_cyc_o, grant);
        end else passed_checks++;
        tick();
        #1;
        total_checks++;
        if ({bus.wbs_cyc_o, bus.wbs_stb_o, grant} !== 5'b11010) begin
            $display("[TB] FAIL single_grant: got cyc %b stb %b grant %b want 1 1 010", bus.wbs_cyc_o, bus.wbs_stb_o, grant);
        end else passed_checks++;
        total_checks++;
        if (bus.wbs_adr_o !== 32'h0000_2040) begin
            $display("[TB] FAIL single_adr: got %h want 00002040", bus.wbs_adr_o);
        end else passed_checks++;
        tick();
        bus.wbs_ack_i = 1'b1;
        bus.wbs_dat_i = 32'hCAFE_0001;
        #1;
        total_checks++;
        if (bus.wbm_ack_o !== 3'b010 || bus.wbm_dat_o !== 32'hCAFE_0001) begin
            $display("[TB] FAIL single_ack: got ack %b dat %h want 010 cafe0001", bus.wbm_ack_o, bus.wbm_dat_o);
        end else passed_checks++;
        tick();
        bus.wbs_ack_i = 1'b0;
        set_master(1, 1'b0, 1'b0, '0, CTI_CLASSIC);
        #1;
        tick();
        #1;
        total_checks++;
        if ({bus.wbs_cyc_o, grant} !== 4'b0000) begin
            $display("[TB] FAIL single_release: got cyc %b grant %b want 0 000", bus.wbs_cyc_o, grant);
        end else passed_checks++;
    endtask

    task automatic test_priority_order();
        logic [NM-1:0] want;
        do_reset();
        tick();
        for (int k = 0; k < NM; k++) set_master(k, 1'b1, 1'b0, 32'h100 * (k + 1), CTI_CLASSIC);
        for (int k = 0; k < NM; k++) begin
            #1;
            total_checks++;
            if (grant !== '0) begin
                $display("[TB] FAIL order_dead_cycle%0d: got grant %b want 000", k, grant);
            end else passed_checks++;
            want    = '0;
            want[k] = 1'b1;
            tick();
            bus.wbs_ack_i = 1'b1;
            bus.wbs_dat_i = 32'hD000_0000 + k;
            #1;
            total_checks++;
            if (grant !== want || bus.wbs_adr_o !== 32'h100 * (k + 1)) begin
                $display("[TB] FAIL order_grant%0d: got grant %b adr %h want %b %h", k, grant, bus.wbs_adr_o, want, 32'h100 * (k + 1));
            end else passed_checks++;
            total_checks++;
            if (bus.wbm_ack_o !== want) begin
                $display("[TB] FAIL order_ack%0d: got %b want %b", k, bus.wbm_ack_o, want);
            end else passed_checks++;
            tick();
            bus.wbs_ack_i = 1'b0;
            set_master(k, 1'b0, 1'b0, '0, CTI_CLASSIC);
            #1;
            tick();
        end
    endtask

    task automatic test_burst_hold();
        int acks0;
        int leaks;
        int cti_bad;
        logic [2:0] cti;
        do_reset();
        tick();
        set_master(0, 1'b1, 1'b0, 32'h4000, CTI_INCR);
        set_master(2, 1'b1, 1'b1, 32'h8000, CTI_CLASSIC);
        acks0   = 0;
        leaks   = 0;
        cti_bad = 0;
        for (int b = 0; b < 8; b++) begin
            tick();
            cti = (b == 7) ? CTI_EOB : CTI_INCR;
            set_master(0, 1'b1, 1'b0, 32'h4000 + 4 * b, cti);
            bus.wbs_ack_i = 1'b1;
            bus.wbs_dat_i = $urandom;
            #1;
            if (bus.wbm_ack_o === 3'b001 && grant === 3'b001) acks0++;
            if (bus.wbm_ack_o[2] !== 1'b0 || bus.wbm_ack_o[1] !== 1'b0) leaks++;
            if (bus.wbs_cti_o !== cti || bus.wbs_adr_o !== 32'h4000 + 4 * b) cti_bad++;
        end
        total_checks++;
        if (acks0 != 8) begin
            $display("[TB] FAIL burst_acks: got %0d owner acks want 8", acks0);
        end else passed_checks++;
        total_checks++;
        if (leaks != 0 || cti_bad != 0) begin
            $display("[TB] FAIL burst_passthru: got leaks %0d cti/adr errors %0d want 0 0", leaks, cti_bad);
        end else passed_checks++;
        tick();
        bus.wbs_ack_i = 1'b0;
        set_master(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
        #1;
        tick();
        #1;
        total_checks++;
        if (grant !== 3'b000) begin
            $display("[TB] FAIL burst_dead_cycle: got grant %b want 000", grant);
        end else passed_checks++;
        tick();
        bus.wbs_ack_i = 1'b1;
        #1;
        total_checks++;
        if (grant !== 3'b100 || bus.wbm_ack_o !== 3'b100 || bus.wbs_we_o !== 1'b1) begin
            $display("[TB] FAIL burst_next_owner: got grant %b ack %b we %b want 100 100 1", grant, bus.wbm_ack_o, bus.wbs_we_o);
        end else passed_checks++;
        tick();
        bus.wbs_ack_i = 1'b0;
        set_master(2, 1'b0, 1'b0, '0, CTI_CLASSIC);
        tick();
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        tick();
        set_master(1, 1'b1, 1'b0, 32'h0000_0BAD, CTI_CLASSIC);
        early = 0;
        for (int c = 0; c < TO; c++) begin
            tick();
            #1;
            if (bus.wbm_err_o !== 3'b000 || timeout !== 1'b0) early++;
        end
        total_checks++;
        if (early != 0) begin
            $display("[TB] FAIL timeout_early: got %0d early error cycles want 0", early);
        end else passed_checks++;
        tick();
        #1;
        total_checks++;
        if (bus.wbm_err_o !== 3'b010 || timeout !== 1'b1) begin
            $display("[TB] FAIL timeout_pulse: got err %b timeout %b want 010 1", bus.wbm_err_o, timeout);
        end else passed_checks++;
        tick();
        set_master(0, 1'b1, 1'b0, 32'h0000_0600, CTI_CLASSIC);
        #1;
        total_checks++;
        if ({bus.wbs_cyc_o, bus.wbs_stb_o, timeout} !== 3'b000 || bus.wbm_err_o !== '0 || grant !== 3'b010) begin
            $display("[TB] FAIL timeout_abort: got cyc %b stb %b to %b err %b grant %b want 0 0 0 000 010",
                     bus.wbs_cyc_o, bus.wbs_stb_o, timeout, bus.wbm_err_o, grant);
        end else passed_checks++;
        tick();
        set_master(1, 1'b0, 1'b0, '0, CTI_CLASSIC);
        #1;
        tick();
        #1;
        total_checks++;
        if (grant !== 3'b000) begin
            $display("[TB] FAIL timeout_idle: got grant %b want 000", grant);
        end else passed_checks++;
        tick();
        #1;
        total_checks++;
        if (grant !== 3'b001 || bus.wbs_adr_o !== 32'h0000_0600) begin
            $display("[TB] FAIL timeout_waiter: got grant %b adr %h want 001 00000600", grant, bus.wbs_adr_o);
        end else passed_checks++;
        set_master(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
        tick();
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        tick();
        set_master(1, 1'b1, 1'b0, 32'h0000_0C00, CTI_CLASSIC);
        repeat (TO) tick();
        tick();
        bus.wbs_ack_i = 1'b1;
        #1;
        total_checks++;
        if (bus.wbm_ack_o !== 3'b010 || bus.wbm_err_o !== 3'b000 || timeout !== 1'b0) begin
            $display("[TB] FAIL limit_ack: got ack %b err %b to %b want 010 000 0", bus.wbm_ack_o, bus.wbm_err_o, timeout);
        end else passed_checks++;
        tick();
        bus.wbs_ack_i = 1'b0;
        #1;
        total_checks++;
        if (bus.wbs_cyc_o !== 1'b1 || timeout !== 1'b0 || bus.wbm_err_o !== 3'b000) begin
            $display("[TB] FAIL limit_no_abort: got cyc %b to %b err %b want 1 0 000", bus.wbs_cyc_o, timeout, bus.wbm_err_o);
        end else passed_checks++;
        set_master(1, 1'b0, 1'b0, '0, CTI_CLASSIC);
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        tick();
        set_master(1, 1'b1, 1'b1, 32'h0000_3000, CTI_INCR);
        for (int b = 0; b < 3; b++) begin
            tick();
            bus.wbs_ack_i = 1'b1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        total_checks++;
        if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o} !== 3'b000 || bus.wbs_adr_o !== '0) begin
            $display("[TB] FAIL midreset_slave: got cyc %b stb %b we %b adr %h want 0 0 0 0",
                     bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_adr_o);
        end else passed_checks++;
        total_checks++;
        if ({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o, grant} !== '0) begin
            $display("[TB] FAIL midreset_resp: got ack %b err %b rty %b grant %b want 0",
                     bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o, grant);
        end else passed_checks++;
        bus.wbs_ack_i = 1'b0;
        for (int k = 0; k < NM; k++) set_master(k, 1'b1, 1'b0, 32'h50 + k, CTI_CLASSIC);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        total_checks++;
        if (grant !== 3'b001) begin
            $display("[TB] FAIL midreset_priority: got grant %b want 001", grant);
        end else passed_checks++;
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [NM-1:0] pending;
        logic [NM-1:0] want;
        logic [AW-1:0] adr_tab [NM];
        logic          we_tab  [NM];
        logic [DW-1:0] rdata;
        int            last;
        int            exp;
        int            w;
        do_reset();
        last = NM - 1;
        for (int r = 0; r < 20; r++) begin
            tick();
            pending = NM'($urandom_range(1, (1 << NM) - 1));
            for (int k = 0; k < NM; k++) begin
                adr_tab[k] = $urandom;
                we_tab[k]  = 1'($urandom_range(0, 1));
                if (pending[k]) set_master(k, 1'b1, we_tab[k], adr_tab[k], CTI_CLASSIC);
            end
            while (pending != '0) begin
                #1;
                total_checks++;
                if (grant !== '0) begin
                    $display("[TB] FAIL rand_idle r%0d: got grant %b want 000", r, grant);
                end else passed_checks++;
                exp = -1;
                for (int i = 1; i <= NM; i++) begin
                    if (exp < 0 && pending[(last + i) % NM]) exp = (last + i) % NM;
                end
                want      = '0;
                want[exp] = 1'b1;
                tick();
                #1;
                total_checks++;
                if (grant !== want || bus.wbs_adr_o !== adr_tab[exp] || bus.wbs_we_o !== we_tab[exp]) begin
                    $display("[TB] FAIL rand_grant r%0d: got grant %b adr %h we %b want %b %h %b",
                             r, grant, bus.wbs_adr_o, bus.wbs_we_o, want, adr_tab[exp], we_tab[exp]);
                end else passed_checks++;
                total_checks++;
                if (bus.wbs_dat_o !== (adr_tab[exp] ^ 32'h5A5A_5A5A)) begin
                    $display("[TB] FAIL rand_wdata r%0d: got %h want %h", r, bus.wbs_dat_o, adr_tab[exp] ^ 32'h5A5A_5A5A);
                end else passed_checks++;
                w = $urandom_range(0, 2);
                for (int j = 0; j < w; j++) begin
                    tick();
                    #1;
                    total_checks++;
                    if (bus.wbm_ack_o !== '0) begin
                        $display("[TB] FAIL rand_wait_ack r%0d: got %b want 000", r, bus.wbm_ack_o);
                    end else passed_checks++;
                end
                rdata = $urandom;
                bus.wbs_ack_i = 1'b1;
                bus.wbs_dat_i = rdata;
                #1;
                total_checks++;
                if (bus.wbm_ack_o !== want || bus.wbm_err_o !== '0 || bus.wbm_dat_o !== rdata) begin
                    $display("[TB] FAIL rand_ack r%0d: got ack %b err %b dat %h want %b 000 %h",
                             r, bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_dat_o, want, rdata);
                end else passed_checks++;
                tick();
                bus.wbs_ack_i = 1'b0;
                set_master(exp, 1'b0, 1'b0, '0, CTI_CLASSIC);
                pending[exp] = 1'b0;
                last         = exp;
                #1;
                total_checks++;
                if (bus.wbs_cyc_o !== 1'b0) begin
                    $display("[TB] FAIL rand_drop r%0d: got cyc %b want 0", r, bus.wbs_cyc_o);
                end else passed_checks++;
                tick();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_priority_order();
        test_burst_hold();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/sysram_arbiter.md
# sysram_arbiter

Round-robin Wishbone B3 arbiter that shares one system-memory slave (the sysram / future DDR3 controller port) between up to NUM_MASTERS masters (CPU data bus, CPU instruction bus, debug master, future DMA). It owns the slave for a whole master cycle, including CTI-encoded bursts. A per-cycle watchdog aborts transfers the slave never acknowledges. It sits between the intercon master ports and the memory slave in the top level.

## Interface
- NUM_MASTERS, 3: number of requesting masters, 2..8
- AW, 32: address width
- DW, 32: data width; select width is DW/8
- TIMEOUT_CYCLES, 255: cycles with stb high and no ack/err/rty before abort; 0 disables the watchdog

- wb_clk_i  in  1  clock; all logic on the rising edge
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- wbm_adr_i / wbm_dat_i  in  NUM_MASTERS*AW / NUM_MASTERS*DW  packed per-master address / write data; master k in slice k
- wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects
- wbm_cti_i / wbm_bte_i  in  NUM_MASTERS*3 / NUM_MASTERS*2  burst type
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  per-master strobes
- wbm_dat_o  out  DW  slave read data, broadcast to all masters
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  responses, only owner's bit can be high
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_we_o, wbs_cyc_o, wbs_stb_o  out  AW/DW/DW/8/3/2/1/1/1  to slave
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  DW/1/1/1  from slave
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle
- timeout_o  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, OWN, ABORT.
- IDLE: if any wbm_cyc_i set, pick first requester scanning from last_owner+1 upward with wrap; register owner, go OWN. No requester: stay IDLE.
- OWN: slave outputs = owner's inputs (combinational mux on registered owner); wbs_cyc_o/wbs_stb_o = owner's cyc/stb. Slave ack/err/rty routed to owner bit only; other masters see 0. Owner held for the whole cyc, regardless of CTI (classic, incrementing, end-of-burst). Owner drops cyc -> IDLE; last_owner <= owner.
- Watchdog: counter (width clog2(TIMEOUT_CYCLES+1)) clears on any slave ack/err/rty or when owner stb low, increments otherwise; saturates. Reaching TIMEOUT_CYCLES -> wbm_err_o[owner] and timeout_o high for one cycle, go ABORT.
- ABORT: wbs_cyc_o/wbs_stb_o forced 0, all responses 0; owner drops cyc -> IDLE, last_owner <= owner.
- Slave response in the same cycle the watchdog expires: response wins, counter clears, no abort.
- Non-owner cyc/stb ignored entirely; they wait without timeout.
- Reset: state IDLE, last_owner = NUM_MASTERS-1 (master 0 first priority), counter 0; all wbs_* outputs 0, all wbm_ack/err/rty_o 0, grant_o 0, timeout_o 0. Reset mid-transfer drops wbs_cyc_o immediately (asynchronous).

## Timing
- Arbitration latency: master cyc in cycle N -> wbs_cyc_o in cycle N+1 when IDLE.
- Release: owner cyc low in cycle M -> IDLE in M+1; next grant registered at M+1, wbs_cyc_o for the new owner at M+2 (one dead cycle between owners).
- Response path slave->master is combinational, zero added latency; registered-feedback bursts pass through unmodified.
- Abort: err pulse exactly TIMEOUT_CYCLES cycles after last response/stb rise.
- wbm_dat_o = wbs_dat_i always (no mux).

## Structure
- Package sysram_arbiter_pkg: state enum (IDLE, OWN, ABORT), CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111), max-master constant 8.
- Sub-module rr_pick: combinational round-robin picker (req vector, last_owner -> one-hot grant, valid); reused by future arbiters.

## Test plan
- Reset then master 1 single read, slave acks in 2 cycles -> wbs_cyc_o one cycle after cyc, wbm_ack_o = 3'b010, data returned, grant_o back to 0 after cyc drop.
- Masters 0,1,2 request simultaneously from reset -> grants in order 0,1,2, one dead cycle between, no response leaks to non-owners.
- Master 0 holds 8-beat INCR burst (CTI 010..111) while master 2 requests -> master 2 granted only after master 0 drops cyc; all 8 acks reach master 0.
- TIMEOUT_CYCLES=4, slave never acks -> err to owner and timeout_o exactly 4 cycles after stb, wbs_cyc_o 0 in ABORT, IDLE after owner drops cyc.
- Slave ack coincident with counter reaching limit -> ack delivered, no err, no timeout_o.
- Assert wb_rst_n_i mid-burst -> all wbs_* and wbm_* response outputs 0 in the same cycle; after release master 0 has first priority.
